// File: rtl/l23_debuffer.sv
// Purpose : strips a per-frame header (strip_len bytes) from an 8-bit stream and forwards
//           only complete, error-free payloads through a store-and-forward byte buffer.
// Latency : first payload byte is valid 3 cycles after the cycle accepting the committing tlast.
// Backpres: input is never back-pressured; frames that do not fit are dropped and counted.
// Ports   : L23_clk/L23_rst (sync, active-high); L23i_* input stream (tuser = frame error,
//           qualified by tlast); L23o_* output stream; *_mgmt_0 register write port
//           (addr 0 = strip_len, addr 1 bit0 = enable); stat_* saturating drop counters.
module l23_debuffer #(
  parameter int ADDR_W = 11
) (
  input  logic        L23_clk,
  input  logic        L23_rst,
  input  logic [7:0]  L23i_tdata,
  input  logic        L23i_tvalid,
  input  logic        L23i_tlast,
  input  logic        L23i_tuser,
  output logic        L23i_tready,
  output logic [7:0]  L23o_tdata,
  output logic        L23o_tvalid,
  output logic        L23o_tlast,
  input  logic        L23o_tready,
  input  logic [15:0] writedata_mgmt_0,
  input  logic [3:0]  writeaddr_mgmt_0,
  input  logic        we_mgmt_0,
  output logic [15:0] stat_runt_cnt,
  output logic [15:0] stat_err_cnt,
  output logic [15:0] stat_ovf_cnt
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_STRIP, W_STORE, W_DROP} wstate_t;

  // Buffer word = {tlast, tdata}
  logic [8:0]        r_mem [DEPTH];

  logic [7:0]        r_strip_len;
  logic              r_enable;
  logic [7:0]        r_lat_strip;
  logic              r_sof;
  wstate_t           r_state;
  logic [7:0]        r_strip_cnt;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_commit_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_rdy;
  logic [15:0]       r_runt_cnt;
  logic [15:0]       r_err_cnt;
  logic [15:0]       r_ovf_cnt;
  logic              r_p_vld;
  logic [8:0]        r_p_dat;
  logic              r_o_vld;
  logic [7:0]        r_o_dat;
  logic              r_o_last;

  logic              w_acc;
  logic [7:0]        w_strip_eff;
  logic              w_en_eff;
  logic [7:0]        w_cnt_inc;
  logic              w_full;
  logic              w_empty;
  logic              w_o_free;
  logic              w_p_move;
  logic              w_rd_issue;

  wstate_t           w_state_nxt;
  logic              w_store;
  logic              w_mem_we;
  logic [ADDR_W:0]   w_wr_ptr_nxt;
  logic [ADDR_W:0]   w_commit_nxt;
  logic [7:0]        w_cnt_nxt;
  logic              w_runt_inc;
  logic              w_err_inc;
  logic              w_ovf_inc;

  // tready is forced low combinationally during reset and, via r_rdy, for one more cycle.
  assign L23i_tready = r_rdy & ~L23_rst;
  assign w_acc       = L23i_tvalid & L23i_tready;

  // Frame parameters are taken live on the first byte and from the latched copy afterwards,
  // so management writes landing mid-frame only apply to the next frame. Enable only matters
  // on the first byte: a disabled frame leaves W_STRIP immediately.
  assign w_strip_eff = r_sof ? r_strip_len : r_lat_strip;
  assign w_en_eff    = ~r_sof | r_enable;
  assign w_cnt_inc   = r_strip_cnt + 8'd1;

  // Uncommitted bytes count towards fullness; committed bytes are freed once read from RAM.
  assign w_full  = (r_wr_ptr - r_rd_ptr) == FULL_LVL;
  assign w_empty = (r_rd_ptr == r_commit_ptr);

  always_ff @(posedge L23_clk) begin
    if (L23_rst) r_state <= W_STRIP;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_store      = 1'b0;
    w_mem_we     = 1'b0;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_cnt_nxt    = r_strip_cnt;
    w_runt_inc   = 1'b0;
    w_err_inc    = 1'b0;
    w_ovf_inc    = 1'b0;
    if (w_acc) begin
      case (r_state)
        W_STRIP: begin
          if (!w_en_eff) begin
            if (!L23i_tlast) w_state_nxt = W_DROP;
          end else if (w_strip_eff == 8'd0) begin
            // Nothing to strip: this byte is already payload.
            w_store = 1'b1;
          end else if (L23i_tlast) begin
            // Frame ended within (or exactly at the end of) the header.
            w_runt_inc = 1'b1;
            w_cnt_nxt  = 8'd0;
          end else if (w_cnt_inc == w_strip_eff) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = W_STORE;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        W_STORE: w_store = 1'b1;
        W_DROP:  if (L23i_tlast) w_state_nxt = W_STRIP;
        default: w_state_nxt = W_STRIP;
      endcase

      if (w_store) begin
        if (w_full) begin
          w_wr_ptr_nxt = r_commit_ptr;
          w_ovf_inc    = 1'b1;
          w_state_nxt  = L23i_tlast ? W_STRIP : W_DROP;
        end else if (L23i_tlast && L23i_tuser) begin
          w_wr_ptr_nxt = r_commit_ptr;
          w_err_inc    = 1'b1;
          w_state_nxt  = W_STRIP;
        end else begin
          w_mem_we     = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
          if (L23i_tlast) begin
            w_commit_nxt = r_wr_ptr + PTR_ONE;
            w_state_nxt  = W_STRIP;
          end else begin
            w_state_nxt  = W_STORE;
          end
        end
      end
    end
  end

  // Read pipeline: RAM read register (p stage) feeding the output register (o stage).
  // A RAM read is issued only when the p stage is empty or draining this cycle, so the
  // o stage holds steady under back-pressure while still streaming 1 byte/cycle.
  assign w_o_free   = ~r_o_vld | L23o_tready;
  assign w_p_move   = r_p_vld & w_o_free;
  assign w_rd_issue = ~w_empty & (~r_p_vld | w_p_move);

  // RAM: no reset on contents or read register, so it maps onto block memory.
  always_ff @(posedge L23_clk) begin
    if (w_mem_we) r_mem[r_wr_ptr[ADDR_W-1:0]] <= {L23i_tlast, L23i_tdata};
    if (w_rd_issue) r_p_dat <= r_mem[r_rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge L23_clk) begin
    if (L23_rst) begin
      r_strip_len  <= 8'd0;
      r_enable     <= 1'b1;
      r_lat_strip  <= 8'd0;
      r_sof        <= 1'b1;
      r_strip_cnt  <= 8'd0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_rdy        <= 1'b0;
      r_runt_cnt   <= 16'd0;
      r_err_cnt    <= 16'd0;
      r_ovf_cnt    <= 16'd0;
      r_p_vld      <= 1'b0;
      r_o_vld      <= 1'b0;
      r_o_dat      <= 8'd0;
      r_o_last     <= 1'b0;
    end else begin
      r_rdy <= 1'b1;

      if (we_mgmt_0) begin
        if (writeaddr_mgmt_0 == 4'd0) r_strip_len <= writedata_mgmt_0[7:0];
        if (writeaddr_mgmt_0 == 4'd1) r_enable    <= writedata_mgmt_0[0];
      end

      if (w_acc) begin
        r_sof <= L23i_tlast;
        if (r_sof) r_lat_strip <= r_strip_len;
      end

      r_strip_cnt  <= w_cnt_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_nxt;

      if (w_runt_inc && r_runt_cnt != 16'hFFFF) r_runt_cnt <= r_runt_cnt + 16'd1;
      if (w_err_inc  && r_err_cnt  != 16'hFFFF) r_err_cnt  <= r_err_cnt  + 16'd1;
      if (w_ovf_inc  && r_ovf_cnt  != 16'hFFFF) r_ovf_cnt  <= r_ovf_cnt  + 16'd1;

      if (w_rd_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_p_vld <= w_rd_issue | (r_p_vld & ~w_p_move);

      if (w_p_move) begin
        r_o_vld  <= 1'b1;
        r_o_dat  <= r_p_dat[7:0];
        r_o_last <= r_p_dat[8];
      end else if (w_o_free) begin
        r_o_vld  <= 1'b0;
      end
    end
  end

  assign L23o_tvalid   = r_o_vld;
  assign L23o_tdata    = r_o_dat;
  assign L23o_tlast    = r_o_last;
  assign stat_runt_cnt = r_runt_cnt;
  assign stat_err_cnt  = r_err_cnt;
  assign stat_ovf_cnt  = r_ovf_cnt;

endmodule

// File: tb/tb_l23_debuffer.sv
// Purpose : directed bench for l23_debuffer (ADDR_W=6) with a frame-level reference model.
// Latency : n/a (bench).
// Backpres: drives downstream tready as always-1, always-0 or toggling per test.
module tb_l23_debuffer;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;

  logic        L23_clk = 1'b0;
  logic        L23_rst = 1'b1;
  logic [7:0]  L23i_tdata = 8'd0;
  logic        L23i_tvalid = 1'b0;
  logic        L23i_tlast = 1'b0;
  logic        L23i_tuser = 1'b0;
  logic        L23i_tready;
  logic [7:0]  L23o_tdata;
  logic        L23o_tvalid;
  logic        L23o_tlast;
  logic        L23o_tready;
  logic [15:0] writedata_mgmt_0 = 16'd0;
  logic [3:0]  writeaddr_mgmt_0 = 4'd0;
  logic        we_mgmt_0 = 1'b0;
  logic [15:0] stat_runt_cnt;
  logic [15:0] stat_err_cnt;
  logic [15:0] stat_ovf_cnt;

  l23_debuffer #(.ADDR_W(AW)) dut (
    .L23_clk(L23_clk), .L23_rst(L23_rst),
    .L23i_tdata(L23i_tdata), .L23i_tvalid(L23i_tvalid), .L23i_tlast(L23i_tlast),
    .L23i_tuser(L23i_tuser), .L23i_tready(L23i_tready),
    .L23o_tdata(L23o_tdata), .L23o_tvalid(L23o_tvalid), .L23o_tlast(L23o_tlast),
    .L23o_tready(L23o_tready),
    .writedata_mgmt_0(writedata_mgmt_0), .writeaddr_mgmt_0(writeaddr_mgmt_0),
    .we_mgmt_0(we_mgmt_0),
    .stat_runt_cnt(stat_runt_cnt), .stat_err_cnt(stat_err_cnt), .stat_ovf_cnt(stat_ovf_cnt)
  );

  always #5 L23_clk = ~L23_clk;

  int cyc = 0;
  always @(posedge L23_clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic eq(input string name, input longint act, input longint req);
    chk(act == req, name, act, req);
  endtask

  // Reference model state: management registers, expected drop counts, expected bytes.
  int          m_strip = 0;
  bit          m_en = 1'b1;
  int          m_runt = 0;
  int          m_err = 0;
  int          m_ovf = 0;
  logic [8:0]  exp_q[$];

  // Observation state kept by the compare process.
  int          out_cnt = 0;
  int          mark = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic [7:0]  first_dat = 8'd0;
  logic [7:0]  last_dat = 8'd0;
  bit          lat_armed = 1'b0;
  int          lat_t = 0;

  int          omode = 0;  // 0: tready=1, 1: tready=0, 2: toggle

  initial begin : otrdy
    L23o_tready = 1'b1;
    forever begin
      @(posedge L23_clk);
      #1;
      case (omode)
        0:       L23o_tready = 1'b1;
        1:       L23o_tready = 1'b0;
        default: L23o_tready = ~L23o_tready;
      endcase
    end
  end

  initial begin : cmp
    bit         stall;
    logic [8:0] held;
    logic [8:0] e;
    stall = 1'b0;
    held  = 9'd0;
    forever begin
      @(negedge L23_clk);
      if (L23_rst) begin
        stall = 1'b0;
      end else begin
        if (stall)
          eq("hold_stable", {L23o_tvalid, L23o_tlast, L23o_tdata}, {1'b1, held});
        if (lat_armed && L23o_tvalid) begin
          chk((cyc - lat_t) <= 3, "commit_latency", cyc - lat_t, 3);
          lat_armed = 1'b0;
        end
        if (L23o_tvalid && L23o_tready) begin
          chk(exp_q.size() > 0, "unexpected_out", L23o_tdata, -1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            eq("out_byte", {L23o_tlast, L23o_tdata}, e);
          end
          if (out_cnt == mark) begin
            first_cyc = cyc;
            first_dat = L23o_tdata;
          end
          last_cyc = cyc;
          last_dat = L23o_tdata;
          out_cnt++;
        end
        stall = L23o_tvalid && !L23o_tready;
        held  = {L23o_tlast, L23o_tdata};
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got cycle %0d, required finish before it", cyc);
    $fatal(1, "timeout");
  end

  task automatic mgmt_wr(input logic [3:0] addr, input logic [15:0] data);
    writeaddr_mgmt_0 = addr;
    writedata_mgmt_0 = data;
    we_mgmt_0        = 1'b1;
    @(posedge L23_clk);
    #1;
    we_mgmt_0 = 1'b0;
    if (addr == 4'd0) m_strip = int'(data[7:0]);
    if (addr == 4'd1) m_en = data[0];
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last, input bit user, input bit arm);
    bit acc;
    acc = 1'b0;
    L23i_tdata  = d;
    L23i_tvalid = 1'b1;
    L23i_tlast  = last;
    L23i_tuser  = user & last;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge L23_clk);
      if (L23i_tready) begin
        acc = 1'b1;
        if (arm) begin
          lat_t     = cyc;
          lat_armed = 1'b1;
        end
      end
      @(posedge L23_clk);
      #1;
    end
    chk(acc, "in_accept", acc, 1);
    L23i_tvalid = 1'b0;
    L23i_tlast  = 1'b0;
    L23i_tuser  = 1'b0;
  endtask

  // Frame fate comes straight from the rules: disabled -> silent drop; no payload -> runt;
  // payload larger than the (drained) buffer -> overflow; tuser -> error; else bytes
  // strip..len-1 emerge in order with tlast on the final one.
  task automatic send_frame(input int len, input bit err, input logic [7:0] base,
                            input int wr_at, input logic [7:0] wr_val, input bit arm);
    int s;
    s = m_strip;
    if (!m_en) begin
    end else if (len <= s) begin
      m_runt++;
    end else if ((len - s) > DEPTH) begin
      m_ovf++;
    end else if (err) begin
      m_err++;
    end else begin
      for (int i = s; i < len; i++)
        exp_q.push_back({(i == len - 1), 8'(base + 8'(i))});
    end
    for (int i = 0; i < len; i++) begin
      if (i == wr_at) begin
        writeaddr_mgmt_0 = 4'd0;
        writedata_mgmt_0 = {8'd0, wr_val};
        we_mgmt_0        = 1'b1;
      end
      send_byte(8'(base + 8'(i)), (i == len - 1), err, arm);
      if (i == wr_at) begin
        we_mgmt_0 = 1'b0;
        m_strip   = int'(wr_val);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    repeat (6) begin
      @(posedge L23_clk);
      #1;
    end
    while ((exp_q.size() != 0 || L23o_tvalid) && k < budget) begin
      @(posedge L23_clk);
      #1;
      k++;
    end
    eq("drain_left", exp_q.size(), 0);
  endtask

  task automatic chk_cnt();
    eq("runt_cnt", stat_runt_cnt, m_runt);
    eq("err_cnt",  stat_err_cnt,  m_err);
    eq("ovf_cnt",  stat_ovf_cnt,  m_ovf);
  endtask

  initial begin : main
    // Reset state
    repeat (2) @(posedge L23_clk);
    @(negedge L23_clk);
    eq("rst_in_tready", L23i_tready, 0);
    eq("rst_tvalid", L23o_tvalid, 0);
    eq("rst_tlast",  L23o_tlast, 0);
    eq("rst_tdata",  L23o_tdata, 0);
    eq("rst_runt", stat_runt_cnt, 0);
    eq("rst_err",  stat_err_cnt, 0);
    eq("rst_ovf",  stat_ovf_cnt, 0);
    @(posedge L23_clk);
    #1;
    L23_rst = 1'b0;
    @(negedge L23_clk);
    eq("tready_cycle_after_rst", L23i_tready, 0);
    @(negedge L23_clk);
    eq("tready_up", L23i_tready, 1);
    @(posedge L23_clk);
    #1;

    // 64-byte frame, 14-byte header: bytes 15..64 back-to-back, bounded commit latency
    mgmt_wr(4'd0, 16'd14);
    mark = out_cnt;
    send_frame(64, 1'b0, 8'd1, -1, 8'd0, 1'b1);
    wait_drain(200);
    eq("strip14_count", out_cnt - mark, 50);
    eq("strip14_first", first_dat, 15);
    eq("strip14_last",  last_dat, 64);
    eq("strip14_b2b_span", last_cyc - first_cyc, 49);
    eq("latency_seen", lat_armed, 0);
    chk_cnt();

    // Runts: shorter than the header, and exactly the header; then a good frame
    mark = out_cnt;
    send_frame(10, 1'b0, 8'h20, -1, 8'd0, 1'b0);
    eq("runt_lit1", stat_runt_cnt, 1);
    send_frame(14, 1'b0, 8'h28, -1, 8'd0, 1'b0);
    eq("runt_lit2", stat_runt_cnt, 2);
    send_frame(20, 1'b0, 8'h30, -1, 8'd0, 1'b0);
    wait_drain(200);
    eq("after_runt_count", out_cnt - mark, 6);
    chk_cnt();

    // Mid-frame strip_len write applies only to the following frame
    mark = out_cnt;
    send_frame(30, 1'b0, 8'h50, 5, 8'd3, 1'b0);
    send_frame(10, 1'b0, 8'h70, -1, 8'd0, 1'b0);
    wait_drain(200);
    eq("midwrite_count", out_cnt - mark, 23);

    // Good / errored / good
    mark = out_cnt;
    send_frame(12, 1'b0, 8'h80, -1, 8'd0, 1'b0);
    send_frame(9,  1'b1, 8'h90, -1, 8'd0, 1'b0);
    send_frame(15, 1'b0, 8'hA0, -1, 8'd0, 1'b0);
    wait_drain(200);
    eq("err_lit", stat_err_cnt, 1);
    eq("agc_count", out_cnt - mark, 21);
    chk_cnt();

    // Disabled frame is silently dropped; unmapped addresses are ignored
    mark = out_cnt;
    mgmt_wr(4'd1, 16'd0);
    send_frame(8, 1'b0, 8'hB0, -1, 8'd0, 1'b0);
    mgmt_wr(4'd1, 16'd1);
    mgmt_wr(4'd9, 16'd0);
    mgmt_wr(4'd8, 16'd0);
    send_frame(10, 1'b0, 8'hB8, -1, 8'd0, 1'b0);
    wait_drain(200);
    eq("enable_count", out_cnt - mark, 7);
    chk_cnt();

    // Overflow with downstream stalled, then a fitting frame held until tready returns
    mgmt_wr(4'd0, 16'd0);
    omode = 1;
    repeat (2) begin
      @(posedge L23_clk);
      #1;
    end
    mark = out_cnt;
    send_frame(80, 1'b0, 8'h00, -1, 8'd0, 1'b0);
    eq("ovf_lit1", stat_ovf_cnt, 1);
    send_frame(20, 1'b0, 8'h10, -1, 8'd0, 1'b0);
    repeat (5) begin
      @(posedge L23_clk);
      #1;
    end
    eq("stalled_no_out", out_cnt - mark, 0);
    eq("stalled_tvalid", L23o_tvalid, 1);
    omode = 0;
    wait_drain(200);
    eq("after_ovf_count", out_cnt - mark, 20);
    chk_cnt();

    // Exactly-full frame fits an empty buffer; one byte more overflows
    mark = out_cnt;
    send_frame(64, 1'b0, 8'h40, -1, 8'd0, 1'b0);
    wait_drain(200);
    eq("full64_count", out_cnt - mark, 64);
    send_frame(65, 1'b0, 8'h60, -1, 8'd0, 1'b0);
    wait_drain(200);
    eq("ovf_lit2", stat_ovf_cnt, 2);
    eq("full65_count", out_cnt - mark, 64);
    chk_cnt();

    // Toggling downstream ready
    omode = 2;
    mgmt_wr(4'd0, 16'd2);
    mark = out_cnt;
    send_frame(25, 1'b0, 8'h33, -1, 8'd0, 1'b0);
    send_frame(17, 1'b0, 8'h90, -1, 8'd0, 1'b0);
    wait_drain(400);
    omode = 0;
    eq("toggle_count", out_cnt - mark, 38);
    chk_cnt();

    // Reset on byte 30 of a 60-byte frame
    repeat (3) begin
      @(posedge L23_clk);
      #1;
    end
    for (int i = 0; i < 29; i++) send_byte(8'(8'hC0 + 8'(i)), 1'b0, 1'b0, 1'b0);
    L23i_tdata  = 8'hC0 + 8'd29;
    L23i_tvalid = 1'b1;
    L23_rst     = 1'b1;
    @(negedge L23_clk);
    eq("midrst_tready0", L23i_tready, 0);
    @(posedge L23_clk);
    #1;
    L23_rst     = 1'b0;
    L23i_tvalid = 1'b0;
    exp_q.delete();
    m_strip = 0;
    m_en    = 1'b1;
    m_runt  = 0;
    m_err   = 0;
    m_ovf   = 0;
    @(negedge L23_clk);
    eq("midrst_tready1", L23i_tready, 0);
    eq("midrst_runt0", stat_runt_cnt, 0);
    eq("midrst_err0",  stat_err_cnt, 0);
    eq("midrst_ovf0",  stat_ovf_cnt, 0);
    @(negedge L23_clk);
    eq("midrst_tready_up", L23i_tready, 1);
    @(posedge L23_clk);
    #1;
    mark = out_cnt;
    send_frame(12, 1'b0, 8'h05, -1, 8'd0, 1'b0);
    wait_drain(200);
    eq("post_rst_count", out_cnt - mark, 12);
    eq("post_rst_first", first_dat, 5);
    chk_cnt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
